// File: rtl/dmadd_pkg.sv
// dmadd_pkg: shared definitions for the dmadd_seq command sequencer.
//   - op encodings carried on cmd_op / dp_insn
//   - FSM state enum used by dmadd_seq
//   - default RUN cycle limit used when DMADD_SEQ_TIMEOUT_EN is defined
package dmadd_pkg;

    localparam logic [1:0] OP_MIN  = 2'b00;
    localparam logic [1:0] OP_MAX  = 2'b01;
    localparam logic [1:0] OP_MADD = 2'b10;
    localparam logic [1:0] OP_BAD  = 2'b11;

    localparam int RUN_TIMEOUT_DEFAULT = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_INIT   = 3'd2,
        ST_LOAD   = 3'd3,
        ST_RUN    = 3'd4,
        ST_RESULT = 3'd5
    } state_e;

endpackage

// File: rtl/dmadd_seq_if.sv
// dmadd_seq_if: host-side command and result handshakes of dmadd_seq.
//   cmd_valid/cmd_ready : command beat handshake (cmd_op, cmd_index, cmd_data, cmd_last)
//   res_valid/res_ready : result handshake (res_data, res_err)
// modport master = host, modport slave = sequencer.
interface dmadd_seq_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_index;
    logic [3:0] cmd_data;
    logic       cmd_last;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_err;

    modport master (
        output cmd_valid, cmd_op, cmd_index, cmd_data, cmd_last, res_ready,
        input  cmd_ready, res_valid, res_data, res_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_index, cmd_data, cmd_last, res_ready,
        output cmd_ready, res_valid, res_data, res_err
    );

endinterface

// File: rtl/dmadd_run_timer.sv
// dmadd_run_timer: counts RUN cycles starting at 1 and flags the cycle in
// which the count reaches RUN_TIMEOUT. Only present in DMADD_SEQ_TIMEOUT_EN builds.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : return the count to zero
//   enable     : current cycle is a RUN cycle
//   expired    : current RUN cycle is number RUN_TIMEOUT
module dmadd_run_timer #(
    parameter int RUN_TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: count_d is the number of RUN cycles including the current one.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (enable) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_d == 8'(RUN_TIMEOUT));

endmodule

// File: rtl/dmadd_seq.sv
// dmadd_seq: command sequencer driving a min/max/multiply-add datapath.
// A job clears the datapath, optionally initialises it, streams load beats,
// runs it until dp_out_top reads zero and hands the result to the host.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   host (slave)        : command and result handshakes (dmadd_seq_if)
//   dp_rst_n/load/run   : registered datapath controls
//   dp_index/data/insn  : registered datapath operands and instruction
//   dp_out, dp_out_top  : datapath result and step value (0 = done)
//   busy                : high whenever the FSM is not in IDLE
// Build option: DMADD_SEQ_TIMEOUT_EN adds the RUN_TIMEOUT parameter and a RUN
// cycle limit that ends the job with res_err=1.
module dmadd_seq
    import dmadd_pkg::*;
`ifdef DMADD_SEQ_TIMEOUT_EN
#(
    parameter int RUN_TIMEOUT = RUN_TIMEOUT_DEFAULT
)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    dmadd_seq_if.slave  host,
    output logic        dp_rst_n,
    output logic        dp_load,
    output logic        dp_run,
    output logic [3:0]  dp_index,
    output logic [3:0]  dp_data,
    output logic [1:0]  dp_insn,
    input  logic [7:0]  dp_out,
    input  logic [3:0]  dp_out_top,
    output logic        busy
);

    state_e     state_q, state_d;
    logic [1:0] job_op_q, job_op_d;
    logic       in_run_q, in_run_d;
    logic       dp_rst_n_q, dp_rst_n_d;
    logic       dp_load_q, dp_load_d;
    logic       dp_run_q, dp_run_d;
    logic [3:0] dp_index_q, dp_index_d;
    logic [3:0] dp_data_q, dp_data_d;
    logic [1:0] dp_insn_q, dp_insn_d;
    logic [7:0] res_data_q, res_data_d;
    logic       res_err_q, res_err_d;
    logic       cmd_ready_s;
    logic       timeout_s;

`ifdef DMADD_SEQ_TIMEOUT_EN
    dmadd_run_timer #(
        .RUN_TIMEOUT (RUN_TIMEOUT)
    ) u_run_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q != ST_RUN),
        .enable  (state_q == ST_RUN),
        .expired (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state, handshake and datapath-control decode.
    always_comb begin
        state_d     = state_q;
        job_op_d    = job_op_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
        cmd_ready_s = 1'b0;
        dp_load_d   = 1'b0;
        dp_index_d  = dp_index_q;
        dp_data_d   = dp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (host.cmd_valid) begin
                    if (host.cmd_op == OP_BAD) begin
                        // Illegal op is consumed here and reported without touching the datapath.
                        cmd_ready_s = 1'b1;
                        res_data_d  = 8'd0;
                        res_err_d   = 1'b1;
                        state_d     = ST_RESULT;
                    end else begin
                        // Legal op is only peeked; the beat itself is taken in LOAD.
                        job_op_d = host.cmd_op;
                        state_d  = ST_CLEAR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_d = (job_op_q == OP_MADD) ? ST_LOAD : ST_INIT;
            end
            ST_INIT: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                cmd_ready_s = 1'b1;
                if (host.cmd_valid) begin
                    dp_load_d  = 1'b1;
                    dp_index_d = host.cmd_index;
                    dp_data_d  = host.cmd_data;
                    state_d    = host.cmd_last ? ST_RUN : ST_LOAD;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                // in_run_q masks the first RUN cycle, whose dp_out_top predates dp_run.
                if (in_run_q && (dp_out_top == 4'd0)) begin
                    res_data_d = dp_out;
                    res_err_d  = 1'b0;
                    state_d    = ST_RESULT;
                end else if (timeout_s) begin
                    res_data_d = dp_out;
                    res_err_d  = 1'b1;
                    state_d    = ST_RESULT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RESULT: begin
                state_d = host.res_ready ? ST_IDLE : ST_RESULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Level controls are registered from the next state so they line up with it.
        in_run_d   = (state_q == ST_RUN);
        dp_rst_n_d = (state_d != ST_CLEAR);
        dp_run_d   = (state_d == ST_RUN);
        dp_insn_d  = job_op_d;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            job_op_q   <= 2'b00;
            in_run_q   <= 1'b0;
            dp_rst_n_q <= 1'b0;
            dp_load_q  <= 1'b0;
            dp_run_q   <= 1'b0;
            dp_index_q <= 4'd0;
            dp_data_q  <= 4'd0;
            dp_insn_q  <= 2'b00;
            res_data_q <= 8'd0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            job_op_q   <= job_op_d;
            in_run_q   <= in_run_d;
            dp_rst_n_q <= dp_rst_n_d;
            dp_load_q  <= dp_load_d;
            dp_run_q   <= dp_run_d;
            dp_index_q <= dp_index_d;
            dp_data_q  <= dp_data_d;
            dp_insn_q  <= dp_insn_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    // cmd_ready is gated by reset so an illegal op offered during reset is never consumed.
    assign host.cmd_ready = cmd_ready_s & rst_n;
    assign host.res_valid = (state_q == ST_RESULT);
    assign host.res_data  = res_data_q;
    assign host.res_err   = res_err_q;
    assign busy           = (state_q != ST_IDLE);
    assign dp_rst_n       = dp_rst_n_q;
    assign dp_load        = dp_load_q;
    assign dp_run         = dp_run_q;
    assign dp_index       = dp_index_q;
    assign dp_data        = dp_data_q;
    assign dp_insn        = dp_insn_q;

endmodule

// File: tb/tb_dmadd_seq.sv
// tb_dmadd_seq: directed self-checking bench for dmadd_seq with a small
// behavioural datapath and a result scoreboard.
module tb_dmadd_seq;
    import dmadd_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dp_rst_n, dp_load, dp_run;
    logic [3:0] dp_index, dp_data;
    logic [1:0] dp_insn;
    logic [7:0] dp_out;
    logic [3:0] dp_out_top;
    logic       busy;

    dmadd_seq_if h ();

    dmadd_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host       (h),
        .dp_rst_n   (dp_rst_n),
        .dp_load    (dp_load),
        .dp_run     (dp_run),
        .dp_index   (dp_index),
        .dp_data    (dp_data),
        .dp_insn    (dp_insn),
        .dp_out     (dp_out),
        .dp_out_top (dp_out_top),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: MIN/MAX fold the indices, MADD accumulates index*data.
    // After each load it needs three run steps before reporting done.
    logic [7:0] m_acc;
    logic [3:0] m_pend;
    logic       m_first;
    bit         stuck = 1'b0;

    always @(posedge clk) begin
        if (!dp_rst_n) begin
            m_acc   <= 8'd0;
            m_pend  <= 4'd0;
            m_first <= 1'b1;
        end else if (dp_load) begin
            m_pend  <= 4'd3;
            m_first <= 1'b0;
            case (dp_insn)
                OP_MIN:  m_acc <= (m_first || ({4'd0, dp_index} < m_acc)) ? {4'd0, dp_index} : m_acc;
                OP_MAX:  m_acc <= (m_first || ({4'd0, dp_index} > m_acc)) ? {4'd0, dp_index} : m_acc;
                OP_MADD: m_acc <= m_acc + ({4'd0, dp_index} * {4'd0, dp_data});
                default: m_acc <= m_acc;
            endcase
        end else if (dp_run && (m_pend != 4'd0)) begin
            m_pend <= m_pend - 4'd1;
        end
    end

    assign dp_out     = m_acc;
    assign dp_out_top = stuck ? 4'hF : m_pend;

    int checks = 0;
    int errors = 0;
    int rst_pulses = 0;
    int run_cycles = 0;
    int bad_ready = 0;
    logic [8:0] sb_q[$];

    // Per-job activity counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!dp_rst_n) rst_pulses++;
            if (dp_run) run_cycles++;
            if (h.cmd_ready && (dp_run || h.res_valid || !dp_rst_n)) bad_ready++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job();
        @(posedge clk);
        #1;
        rst_pulses = 0;
        run_cycles = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send_beat(input logic [1:0] op, input logic [3:0] idx,
                             input logic [3:0] dat, input logic last);
        bit done = 1'b0;
        h.cmd_valid = 1'b1;
        h.cmd_op    = op;
        h.cmd_index = idx;
        h.cmd_data  = dat;
        h.cmd_last  = last;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (h.cmd_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        h.cmd_valid = 1'b0;
        chk("beat_accept", done, 1);
    endtask

    // Waits for res_valid, checks it against the scoreboard, optionally holds
    // res_ready low for 'hold' cycles, then acknowledges.
    task automatic wait_result(input string tag, input int hold);
        bit seen = 1'b0;
        bit stable = 1'b1;
        logic [8:0] exp;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (h.res_valid) seen = 1'b1;
        end
        chk({tag, "_seen"}, seen, 1);
        if (seen) begin
            chk({tag, "_sb_nonempty"}, (sb_q.size() != 0), 1);
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : 9'h1FF;
            chk({tag, "_res"}, {h.res_err, h.res_data}, exp);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!(h.res_valid && ({h.res_err, h.res_data} === exp) && !h.cmd_ready)) stable = 1'b0;
            end
            if (hold > 0) chk({tag, "_stable"}, stable, 1);
            h.res_ready = 1'b1;
            @(posedge clk);
            #1 h.res_ready = 1'b0;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        h.cmd_valid = 1'b0;
        h.cmd_op    = 2'b00;
        h.cmd_index = 4'd0;
        h.cmd_data  = 4'd0;
        h.cmd_last  = 1'b0;
        h.res_ready = 1'b0;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {dp_rst_n, dp_load, dp_run, dp_insn, dp_index, dp_data,
                            h.cmd_ready, h.res_valid, h.res_data, h.res_err, busy}, 0);
        h.cmd_valid = 1'b1;
        h.cmd_op    = OP_BAD;
        #1 chk("reset_ready", h.cmd_ready, 0);
        h.cmd_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // MIN single beat.
        start_job();
        sb_q.push_back({1'b0, 8'd5});
        send_beat(OP_MIN, 4'd5, 4'd0, 1'b1);
        wait_result("min1", 0);
        chk("min1_rst_pulses", rst_pulses, 1);

        // MIN over three beats.
        start_job();
        sb_q.push_back({1'b0, 8'd4});
        send_beat(OP_MIN, 4'd8, 4'd0, 1'b0);
        send_beat(OP_MIN, 4'd4, 4'd0, 1'b0);
        send_beat(OP_MIN, 4'd6, 4'd0, 1'b1);
        wait_result("min3", 0);

        // MAX, two beats.
        start_job();
        sb_q.push_back({1'b0, 8'd9});
        send_beat(OP_MAX, 4'd3, 4'd0, 1'b0);
        send_beat(OP_MAX, 4'd9, 4'd0, 1'b1);
        wait_result("max2", 0);
        chk("max2_rst_pulses", rst_pulses, 1);

        // MADD; the op on the second beat must be ignored. 3*4 + 2*5 = 22.
        start_job();
        sb_q.push_back({1'b0, 8'd22});
        send_beat(OP_MADD, 4'd3, 4'd4, 1'b0);
        send_beat(OP_MIN, 4'd2, 4'd5, 1'b1);
        wait_result("madd", 0);
        @(negedge clk);
        chk("idle_outputs", {dp_index, dp_data, dp_insn, dp_load, dp_run, dp_rst_n, busy},
            {4'd2, 4'd5, OP_MADD, 1'b0, 1'b0, 1'b1, 1'b0});

        // Illegal op: consumed in one cycle, error result next cycle, no datapath clear.
        start_job();
        sb_q.push_back({1'b1, 8'd0});
        h.cmd_valid = 1'b1;
        h.cmd_op    = OP_BAD;
        @(negedge clk);
        chk("bad_ready", h.cmd_ready, 1);
        @(posedge clk);
        #1 h.cmd_valid = 1'b0;
        @(negedge clk);
        chk("bad_latency", h.res_valid, 1);
        wait_result("bad", 0);
        chk("bad_rst_pulses", rst_pulses, 0);

        // Datapath that never finishes.
        start_job();
        stuck = 1'b1;
`ifdef DMADD_SEQ_TIMEOUT_EN
        sb_q.push_back({1'b1, 8'd7});
        send_beat(OP_MIN, 4'd7, 4'd0, 1'b1);
        wait_result("timeout", 0);
        chk("timeout_run_cycles", run_cycles, 32);
`else
        send_beat(OP_MIN, 4'd7, 4'd0, 1'b1);
        repeat (1000) @(negedge clk);
        chk("no_timeout", {busy, h.res_valid, dp_run}, 3'b101);
        do_reset();
        @(negedge clk);
        chk("no_timeout_reset", {busy, h.res_valid, dp_run}, 3'b000);
`endif

        // One-cycle reset in the middle of RUN aborts the job silently.
        start_job();
        send_beat(OP_MIN, 4'd6, 4'd0, 1'b1);
        repeat (5) @(negedge clk);
        do_reset();
        @(negedge clk);
        chk("rst_mid_run", {busy, h.res_valid, dp_run}, 3'b000);
        stuck = 1'b0;
        start_job();
        sb_q.push_back({1'b0, 8'd2});
        send_beat(OP_MIN, 4'd2, 4'd0, 1'b1);
        wait_result("after_rst", 0);

        // Result held for 10 cycles while the next command is already offered.
        start_job();
        sb_q.push_back({1'b0, 8'd12});
        send_beat(OP_MAX, 4'd1, 4'd0, 1'b0);
        send_beat(OP_MAX, 4'd12, 4'd0, 1'b1);
        h.cmd_valid = 1'b1;
        h.cmd_op    = OP_MIN;
        h.cmd_index = 4'd2;
        h.cmd_data  = 4'd0;
        h.cmd_last  = 1'b1;
        wait_result("hold", 10);
        sb_q.push_back({1'b0, 8'd2});
        send_beat(OP_MIN, 4'd2, 4'd0, 1'b1);
        wait_result("after_hold", 0);

        chk("ready_outside_load", bad_ready, 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
